// File: rtl/fifo_pkg.sv
// Shared FIFO flag-select constants and read-action encoding.
package fifo_pkg;

  localparam int FIFO_VALID        = 1;
  localparam int FIFO_EMPTY        = 2;
  localparam int FIFO_ALMOST_EMPTY = 4;
  localparam int FIFO_FULL         = 8;
  localparam int FIFO_ALMOST_FULL  = 16;
  localparam int FIFO_COUNT        = 32;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_WORD,
    RD_LOW_HALF,
    RD_HIGH_HALF
  } rd_action_e;

  function automatic bit fifo_has(input int mask, input int flag);
    return (mask & flag) != 0;
  endfunction

endpackage

// File: rtl/fifo_connect_half_width.sv
// Producer/consumer bundle for the half-width-read FIFO.
interface fifo_connect_half_width #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 32
);

  logic [WIDTH-1:0]         datain;
  logic                     write;
  logic                     read;
  logic                     onlyReadHalf;
  logic [WIDTH-1:0]         dataout;
  logic                     valid;
  logic                     empty;
  logic                     almostempty;
  logic                     full;
  logic                     almostfull;
  logic                     halfPending;
  // Fill level, only driven when FIFO_COUNT is selected; zero otherwise.
  logic [$clog2(DEPTH):0]   fillLevel;

  modport fifo (
    input  datain, write, read, onlyReadHalf,
    output dataout, valid, empty, almostempty, full, almostfull, halfPending, fillLevel
  );

  modport user (
    output datain, write, read, onlyReadHalf,
    input  dataout, valid, empty, almostempty, full, almostfull, halfPending, fillLevel
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one write port, one read port (async or registered).
module fifo_mem_dp #(
  parameter int WIDTH    = 6,
  parameter int DEPTH    = 32,
  parameter bit REG_READ = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  generate
    if (REG_READ) begin : g_reg_read
      logic [WIDTH-1:0] rd_data_q;
      always_ff @(posedge clk) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
      assign rd_data_o = rd_data_q;
    end else begin : g_async_read
      assign rd_data_o = mem_q[rd_addr_i];
    end
  endgenerate

endmodule

// File: rtl/fifo_halfwidth_read.sv
// Word-write FIFO with full- or half-word reads and an optional replay (circular) mode.
module fifo_halfwidth_read
  import fifo_pkg::*;
#(
  parameter int WIDTH                 = 6,
  parameter int DEPTH                 = 32,
  parameter int OUTPUTS               = FIFO_VALID | FIFO_EMPTY | FIFO_ALMOST_EMPTY |
                                        FIFO_FULL | FIFO_ALMOST_FULL,
  parameter int TRIGGERALMOSTFULL     = 1,
  parameter int TRIGGERALMOSTEMPTY    = 1,
  parameter bit FIRSTWORD_FALLTHROUGH = 1'b1,
  parameter int CIRCULAR_HALFWAY      = DEPTH / 2,
  parameter bit OUTPUTHALFWORDATEND   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   circular,
  fifo_connect_half_width.fifo   link
);

  localparam int HALF = WIDTH / 2;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  logic [AW-1:0]    wrptr_q, wrptr_d;
  logic [AW-1:0]    rdptr_q, rdptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             half_q, half_d;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] view;
  logic [HALF-1:0]  hi_half;
  logic             is_empty, is_full, wr_en, pop;
  rd_action_e       act;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign wr_en    = link.write && !is_full && !circular;

  fifo_mem_dp #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .REG_READ (1'b0)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wrptr_q),
    .wr_data_i (link.datain),
    .rd_addr_i (rdptr_q),
    .rd_data_o (head)
  );

  // A pending half always finishes the word, whatever onlyReadHalf says.
  always_comb begin
    act = RD_NONE;
    if (link.read && !is_empty) begin
      if (half_q)                 act = RD_HIGH_HALF;
      else if (link.onlyReadHalf) act = RD_LOW_HALF;
      else                        act = RD_WORD;
    end
  end

  assign pop = (act == RD_WORD) || (act == RD_HIGH_HALF);

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    half_d  = half_q;
    if (wr_en) wrptr_d = wrptr_q + 1'b1;
    if (act == RD_LOW_HALF) half_d = 1'b1;
    if (pop) begin
      half_d = 1'b0;
      if (circular && (rdptr_q == AW'(CIRCULAR_HALFWAY - 1))) rdptr_d = '0;
      else                                                    rdptr_d = rdptr_q + 1'b1;
    end
    // Replay pops leave the stored words in place.
    case ({wr_en, pop && !circular})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      half_q  <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      half_q  <= half_d;
    end
  end

  assign hi_half = head[WIDTH-1:HALF];

  always_comb begin
    view = head;
    if (half_q) begin
      if (OUTPUTHALFWORDATEND) view = {hi_half, {HALF{1'b0}}};
      else                     view = {{HALF{1'b0}}, hi_half};
    end
  end

  logic             valid_int;
  logic [WIDTH-1:0] dout_int;

  generate
    if (FIRSTWORD_FALLTHROUGH) begin : g_fwft
      assign valid_int = !is_empty;
      assign dout_int  = is_empty ? '0 : view;
    end else begin : g_registered
      logic             valid_q;
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
          dout_q  <= '0;
        end else begin
          valid_q <= (act != RD_NONE);
          if (act != RD_NONE) dout_q <= view;
        end
      end
      assign valid_int = valid_q;
      assign dout_int  = dout_q;
    end
  endgenerate

  assign link.dataout     = dout_int;
  assign link.halfPending = half_q;
  assign link.valid       = fifo_has(OUTPUTS, FIFO_VALID) ? valid_int : 1'b0;
  assign link.empty       = fifo_has(OUTPUTS, FIFO_EMPTY) ? is_empty : 1'b0;
  assign link.full        = fifo_has(OUTPUTS, FIFO_FULL) ? is_full : 1'b0;
  assign link.almostempty = fifo_has(OUTPUTS, FIFO_ALMOST_EMPTY)
                            ? (count_q <= CW'(TRIGGERALMOSTEMPTY)) : 1'b0;
  assign link.almostfull  = fifo_has(OUTPUTS, FIFO_ALMOST_FULL)
                            ? ((CW'(DEPTH) - count_q) <= CW'(TRIGGERALMOSTFULL)) : 1'b0;
  assign link.fillLevel   = fifo_has(OUTPUTS, FIFO_COUNT) ? count_q : '0;

endmodule

// File: tb/tb_fifo_halfwidth_read.sv
// Randomized bench for fifo_halfwidth_read against a ring-buffer reference model.
module tb_fifo_halfwidth_read;

  localparam int W       = 6;
  localparam int D       = 32;
  localparam int H       = W / 2;
  localparam int HALFWAY = D / 2;

  logic clk = 1'b0;
  logic reset;
  logic circular;

  fifo_connect_half_width #(.WIDTH(W), .DEPTH(D)) lnk ();

  fifo_halfwidth_read dut (
    .clk      (clk),
    .reset    (reset),
    .circular (circular),
    .link     (lnk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: stored words in a ring, count of live words, read slot, half flag.
  logic [W-1:0] mem_m   [D];
  bit           known_m [D];
  int           cnt_m, rd_m, wr_m;
  bit           half_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit rd_ok, pop_ok, wr_ok;
    if (reset) begin
      cnt_m  = 0;
      rd_m   = 0;
      wr_m   = 0;
      half_m = 1'b0;
    end else begin
      rd_ok  = lnk.read && (cnt_m != 0);
      pop_ok = rd_ok && (half_m || !lnk.onlyReadHalf);
      wr_ok  = lnk.write && (cnt_m != D) && !circular;
      if (wr_ok) begin
        mem_m[wr_m]   = lnk.datain;
        known_m[wr_m] = 1'b1;
        wr_m          = (wr_m + 1) % D;
      end
      if (rd_ok && !pop_ok) half_m = 1'b1;
      if (pop_ok) begin
        half_m = 1'b0;
        rd_m   = (circular && rd_m == HALFWAY - 1) ? 0 : (rd_m + 1) % D;
      end
      cnt_m = cnt_m + (wr_ok ? 1 : 0) - ((pop_ok && !circular) ? 1 : 0);
    end
  end

  always @(negedge clk) begin : compare
    logic [W-1:0] word, exp_d;
    bit           emp;
    if (chk_en) begin
      emp  = (cnt_m == 0);
      word = mem_m[rd_m];
      if (emp)         exp_d = '0;
      else if (half_m) exp_d = {{(W-H){1'b0}}, word[W-1:H]};
      else             exp_d = word;
      chk("empty",       lnk.empty,       emp);
      chk("valid",       lnk.valid,       !emp);
      chk("full",        lnk.full,        cnt_m == D);
      chk("almostempty", lnk.almostempty, cnt_m <= 1);
      chk("almostfull",  lnk.almostfull,  (D - cnt_m) <= 1);
      chk("halfPending", lnk.halfPending, half_m);
      if (emp || known_m[rd_m]) chk("dataout", lnk.dataout, exp_d);
    end
  end

  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit h);
    lnk.write        = w;
    lnk.datain       = d;
    lnk.read         = r;
    lnk.onlyReadHalf = h;
    @(posedge clk);
    @(negedge clk);
    lnk.write        = 1'b0;
    lnk.read         = 1'b0;
    lnk.onlyReadHalf = 1'b0;
  endtask

  initial begin : stim
    logic [W-1:0] words [D];
    int           circ_left;
    bit           w, r, h;

    for (int i = 0; i < D; i++) known_m[i] = 1'b0;
    reset            = 1'b1;
    circular         = 1'b0;
    lnk.write        = 1'b0;
    lnk.read         = 1'b0;
    lnk.onlyReadHalf = 1'b0;
    lnk.datain       = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_valid",       lnk.valid,       0);
    chk("rst_dataout",     lnk.dataout,     0);
    chk("rst_empty",       lnk.empty,       1);
    chk("rst_almostempty", lnk.almostempty, 1);
    chk("rst_full",        lnk.full,        0);
    chk("rst_almostfull",  lnk.almostfull,  0);
    chk("rst_halfPending", lnk.halfPending, 0);
    chk_en = 1'b1;

    step(1'b1, 6'b101001, 1'b0, 1'b0);
    step(1'b1, 6'b110010, 1'b0, 1'b0);
    chk("t1_valid",       lnk.valid,       1);
    chk("t1_dataout",     lnk.dataout,     6'b101001);
    chk("t1_empty",       lnk.empty,       0);
    chk("t1_almostempty", lnk.almostempty, 0);

    step(1'b0, '0, 1'b1, 1'b0);
    chk("t2_dataout", lnk.dataout, 6'b110010);

    step(1'b0, '0, 1'b1, 1'b1);
    chk("t3_halfPending", lnk.halfPending, 1);
    chk("t3_dataout",     lnk.dataout,     6'b000110);

    step(1'b1, 6'b111011, 1'b0, 1'b0);
    chk("t4_pending_out", lnk.dataout, 6'b000110);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("t4_dataout",     lnk.dataout,     6'b111011);
    chk("t4_halfPending", lnk.halfPending, 0);
    chk("t4_almostempty", lnk.almostempty, 1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t4_empty", lnk.empty, 1);

    for (int i = 0; i < D; i++) begin
      words[i] = W'($urandom);
      step(1'b1, words[i], 1'b0, 1'b0);
      if (i == D - 3) chk("t5_af_early", lnk.almostfull, 0);
      if (i == D - 2) begin
        chk("t5_almostfull", lnk.almostfull, 1);
        chk("t5_not_full",   lnk.full,       0);
      end
    end
    chk("t5_full", lnk.full, 1);
    step(1'b1, 6'h3f, 1'b0, 1'b0);
    chk("t5_full_after_extra", lnk.full, 1);
    for (int i = 0; i < D; i++) begin
      chk("t5_order", lnk.dataout, words[i]);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t5_empty", lnk.empty, 1);

    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      words[i] = W'($urandom);
      step(1'b1, words[i], 1'b0, 1'b0);
    end
    circular = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("t6_replay", lnk.dataout, words[i % 16]);
      step(i == 5, 6'h15, 1'b1, 1'b0);
    end
    chk("t6_not_empty", lnk.empty, 0);
    chk("t6_not_full",  lnk.full,  0);
    circular = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("t6_drained", lnk.empty, 1);

    circ_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (circ_left > 0) begin
        circ_left--;
        if (circ_left == 0) circular = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        circular  = 1'b1;
        circ_left = $urandom_range(5, 30);
      end
      reset = ($urandom_range(0, 499) == 0);
      w = ($urandom_range(0, 99) < (((n / 100) % 2 == 0) ? 70 : 30));
      r = ($urandom_range(0, 99) < (((n / 100) % 2 == 0) ? 30 : 70));
      h = ($urandom_range(0, 2) == 0);
      step(w, W'($urandom), r, h);
    end
    reset    = 1'b0;
    circular = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
